// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between the SPI slave and the RAM controller.
// The master side is the SPI slave (drives rx words); the slave side is the RAM controller.
interface spi_ram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [9:0]            din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  cmd_err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  cmd_err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output cmd_err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port read-first RAM behind an SPI slave: decodes 2-bit commands, keeps
// write/read address registers with write auto-increment, and presents read data.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_ram_ctrl_if.slave  bus
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RD_ACCESS = 2'd1,
    S_TX_HOLD   = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic [ADDR_SIZE-1:0]  r_rd_addr;
  logic                  r_wr_addr_vld;
  logic                  r_rd_addr_vld;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_ram_oreg;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_tx_valid;
  logic                  r_cmd_err;
  state_t                r_state;
  logic                  r_acc_phase;

  logic [1:0]            w_cmd;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_SIZE-1:0]  w_addr;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_err;
  logic                  w_drop;
  logic                  w_oreg_en;
  state_t                w_state_nxt;
  logic                  w_acc_phase_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_tx_valid_nxt;
  logic                  w_cmd_err_nxt;

  assign w_cmd     = bus.din[9:8];
  assign w_payload = bus.din[DATA_WIDTH-1:0];
  assign w_addr    = bus.din[ADDR_SIZE-1:0];

  assign w_wr_en = bus.rx_valid && (w_cmd == CMD_WR_DATA) && r_wr_addr_vld;
  assign w_rd_en = bus.rx_valid && (w_cmd == CMD_RD_DATA) && r_rd_addr_vld;
  assign w_err   = bus.rx_valid &&
                   (((w_cmd == CMD_WR_DATA) && !r_wr_addr_vld) ||
                    ((w_cmd == CMD_RD_DATA) && !r_rd_addr_vld));
  // A rejected RD_DATA leaves the FSM untouched; every other accepted word releases TX_HOLD.
  assign w_drop  = bus.rx_valid && !((w_cmd == CMD_RD_DATA) && !r_rd_addr_vld);

  assign w_oreg_en = (r_state == S_RD_ACCESS) && !r_acc_phase;

  // RAM core: write and read share the edge order so a read sees pre-write data.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_addr] <= w_payload;
    end
    if (w_rd_en) begin
      r_ram_q <= r_mem[r_rd_addr];
    end
    if (w_oreg_en) begin
      r_ram_oreg <= r_ram_q;
    end
  end

  // Address registers and their valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_wr_addr_vld <= 1'b0;
      r_rd_addr_vld <= 1'b0;
    end else if (bus.rx_valid) begin
      case (w_cmd)
        CMD_WR_ADDR: begin
          r_wr_addr     <= w_addr;
          r_wr_addr_vld <= 1'b1;
        end
        CMD_WR_DATA: begin
          if (r_wr_addr_vld) begin
            r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
          end
        end
        CMD_RD_ADDR: begin
          r_rd_addr     <= w_addr;
          r_rd_addr_vld <= 1'b1;
        end
        default: begin
          r_rd_addr_vld <= 1'b0;
        end
      endcase
    end
  end

  // FSM state register; r_acc_phase marks the second RD_ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc_phase <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_phase <= w_acc_phase_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_phase_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_en) begin
          w_state_nxt = S_RD_ACCESS;
        end
      end
      S_RD_ACCESS: begin
        if (!r_acc_phase) begin
          w_acc_phase_nxt = 1'b1;
        end else begin
          w_state_nxt = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        if (w_rd_en) begin
          w_state_nxt = S_RD_ACCESS;
        end else if (w_drop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic feeding the registered outputs.
  always_comb begin
    w_dout_nxt     = r_dout;
    w_tx_valid_nxt = r_tx_valid;
    w_cmd_err_nxt  = w_err;
    case (r_state)
      S_RD_ACCESS: begin
        if (r_acc_phase) begin
          w_dout_nxt     = r_ram_oreg;
          w_tx_valid_nxt = 1'b1;
        end
      end
      S_TX_HOLD: begin
        if (w_drop) begin
          w_tx_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_dout     <= w_dout_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_cmd_err  <= w_cmd_err_nxt;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.tx_valid = r_tx_valid;
  assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: a driver applies commands to an array-based
// reference model and queues expected events; a monitor checks them at negedge.
module tb_spi_ram_ctrl;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_ram_ctrl_if #(.DATA_WIDTH(8)) bus_if ();

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_wa = 8'h00;
  logic [7:0] m_ra = 8'h00;
  bit         m_wv = 1'b0;
  bit         m_rv = 1'b0;
  int         last_rd = -10;

  rd_t rd_q   [$];
  int  err_q  [$];
  int  drop_q [$];

  int  edge_cnt = 0;
  bit  rst_edge = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;

  bit         holding = 1'b0;
  logic [7:0] held = 8'h00;
  bit         due_now, drop_now, exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_cnt);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    rst_edge = rst;
  end

  // Monitor: pops expected events due at the edge just taken and compares outputs.
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      due_now  = 1'b0;
      drop_now = 1'b0;
      exp_err  = 1'b0;
      while (drop_q.size() > 0 && drop_q[0] <= edge_cnt) begin
        if (drop_q[0] == edge_cnt) drop_now = 1'b1;
        void'(drop_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] <= edge_cnt) begin
        if (err_q[0] == edge_cnt) exp_err = 1'b1;
        void'(err_q.pop_front());
      end
      if (rst_edge) begin
        holding = 1'b0;
        chk("reset_dout", 32'(bus_if.dout), 32'h0);
        chk("reset_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        chk("reset_cmd_err", 32'(bus_if.cmd_err), 32'h0);
      end else begin
        if (rd_q.size() > 0 && rd_q[0].due == edge_cnt) begin
          due_now = 1'b1;
          holding = 1'b1;
          held    = rd_q[0].data;
          void'(rd_q.pop_front());
        end else if (drop_now) begin
          holding = 1'b0;
        end
        chk("tx_valid", 32'(bus_if.tx_valid), 32'(holding));
        if (holding) chk(due_now ? "rd_data" : "dout_hold", 32'(bus_if.dout), 32'(held));
        chk("cmd_err", 32'(bus_if.cmd_err), 32'(exp_err));
      end
    end
  end

  // Driver: one command per call; applies the command rules to the model for edge e.
  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    int e;
    @(negedge clk);
    rst = 1'b0;
    while (c == 2'b11 && m_rv && (edge_cnt + 1 <= last_rd + 2)) begin
      bus_if.rx_valid = 1'b0;
      @(negedge clk);
    end
    e = edge_cnt + 1;
    bus_if.din      = {c, p};
    bus_if.rx_valid = 1'b1;
    case (c)
      2'b00: begin m_wa = p; m_wv = 1'b1; drop_q.push_back(e); end
      2'b01: begin
        if (m_wv) begin m_mem[m_wa] = p; m_wa = m_wa + 8'd1; end
        else err_q.push_back(e);
        drop_q.push_back(e);
      end
      2'b10: begin m_ra = p; m_rv = 1'b1; drop_q.push_back(e); end
      default: begin
        if (m_rv) begin
          rd_t r;
          r.data = m_mem[m_ra];
          r.due  = e + 2;
          rd_q.push_back(r);
          m_rv    = 1'b0;
          last_rd = e;
          drop_q.push_back(e);
        end else begin
          err_q.push_back(e);
        end
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus_if.rx_valid = 1'b0;
      bus_if.din      = 10'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus_if.rx_valid = 1'b0;
      // A read still in flight at the reset edge never appears.
      while (rd_q.size() > 0 && rd_q[rd_q.size()-1].due > edge_cnt) void'(rd_q.pop_back());
    end
    m_wv = 1'b0; m_rv = 1'b0; m_wa = 8'h00; m_ra = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a);
    cmd(2'b10, a);
    cmd(2'b11, 8'($urandom));
    idle(3);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [1:0] c;
    bus_if.din      = '0;
    bus_if.rx_valid = 1'b0;
    do_reset(3);

    // Write without address after reset is rejected.
    cmd(2'b01, 8'h44);
    // Fill the whole array via one burst; wraps back to 0.
    cmd(2'b00, 8'h00);
    for (int i = 0; i < 256; i++) cmd(2'b01, 8'($urandom));

    // Write then read
    cmd(2'b00, 8'h3A); cmd(2'b01, 8'h5C); cmd(2'b10, 8'h3A); cmd(2'b11, 8'h00);
    idle(4);

    // Burst write across the top address
    cmd(2'b00, 8'hFE); cmd(2'b01, 8'h11); cmd(2'b01, 8'h22); cmd(2'b01, 8'h33);
    rd(8'hFE); rd(8'hFF); rd(8'h00);

    // Second RD_DATA without new address is rejected, tx_valid held
    cmd(2'b10, 8'h07); cmd(2'b11, 8'h00); idle(3); cmd(2'b11, 8'h00); idle(2);

    // Read-first collision during RD_ACCESS
    cmd(2'b00, 8'h10); cmd(2'b01, 8'hAA);
    cmd(2'b10, 8'h10); cmd(2'b11, 8'h00); cmd(2'b00, 8'h10); cmd(2'b01, 8'hBB);
    idle(3);
    rd(8'h10);

    // Back-to-back reads: RD_DATA accepted in TX_HOLD
    cmd(2'b10, 8'h20); cmd(2'b11, 8'h00); cmd(2'b10, 8'h21); idle(2);
    cmd(2'b11, 8'h00); idle(4);

    // Reset during TX_HOLD; memory survives
    rd(8'h3A); idle(1);
    do_reset(2);
    rd(8'h3A); rd(8'hFF);

    // Reset right after a read is accepted aborts it
    cmd(2'b10, 8'h05); cmd(2'b11, 8'h00); do_reset(1); idle(3);
    cmd(2'b01, 8'h99); idle(1);

    // Random traffic
    for (int it = 0; it < 900; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) idle(1);
      else if (r < 16) do_reset(int'($urandom_range(1, 2)));
      else begin
        c = 2'($urandom_range(0, 3));
        cmd(c, 8'($urandom));
      end
    end
    idle(6);

    chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
